shift_rot_unit_32: RTL and testbench

//  32-bit barrel shifter/rotator for the Mini-SRC ALU datapath (shl, shr, rol, ror).
//  - Built from three combinational sub-blocks:
//    - left rotator
//    - right rotator
//    - shift-mask generator that zero-fills vacated bits
//  - Result is registered: one-cycle latency into the ALU result path.

---
 rtl/shift_rot_unit_32.sv | 141 ++++++++++++++
 tb/tb_shift_rot_unit_32.sv | 125 ++++++++++++
 2 files changed

// File: rtl/shift_rot_unit_32.sv
// 32-bit barrel shifter/rotator (shl, shr, rol, ror) with a registered result.
// Optional build macro ARITH_SHIFT_EN adds port in_arith for sign-filling right shifts.

// Left rotator: five log-stages; stage gi rotates by 2**gi when amt[gi] is set.
module shift_rot_rotl_32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] result
);
    logic [31:0] stage [0:5];
    genvar gi;

    assign stage[0] = data;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = amt[gi]
                ? {stage[gi][31-STEP:0], stage[gi][31:32-STEP]}
                : stage[gi];
        end
    endgenerate

    assign result = stage[5];
endmodule

// Right rotator: mirror image of the left rotator.
module shift_rot_rotr_32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] result
);
    logic [31:0] stage [0:5];
    genvar gi;

    assign stage[0] = data;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = amt[gi]
                ? {stage[gi][STEP-1:0], stage[gi][31:STEP]}
                : stage[gi];
        end
    endgenerate

    assign result = stage[5];
endmodule

// Keep-mask for shifts: bit set where the rotated value survives. A count of
// 32 or more (any of y[31:5] set) clears the whole mask.
module shift_rot_mask_32 (
    input  logic [31:0] y,
    input  logic        left,
    output logic [31:0] mask
);
    logic [5:0] n_ext;
    logic       over_range;
    genvar gi;

    assign n_ext      = {1'b0, y[4:0]};
    assign over_range = |y[31:5];

    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit
            localparam logic [5:0] BIT_IDX = 6'(gi);
            logic keep_left;
            logic keep_right;
            assign keep_left  = (n_ext <= BIT_IDX);
            assign keep_right = ((BIT_IDX + n_ext) <= 6'd31);
            assign mask[gi]   = ~over_range & (left ? keep_left : keep_right);
        end
    endgenerate
endmodule

module shift_rot_unit_32 (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        in_left,
    input  logic        in_rot,
`ifdef ARITH_SHIFT_EN
    input  logic        in_arith,
`endif
    output logic [31:0] out
);
    logic [31:0] rotl_value;
    logic [31:0] rotr_value;
    logic [31:0] rot_value;
    logic [31:0] keep_mask;
    logic [31:0] fill_bits;
    logic [31:0] out_next;
    logic [31:0] out_reg;

    shift_rot_rotl_32 u_rotl (
        .data   (in_x),
        .amt    (in_y[4:0]),
        .result (rotl_value)
    );

    shift_rot_rotr_32 u_rotr (
        .data   (in_x),
        .amt    (in_y[4:0]),
        .result (rotr_value)
    );

    shift_rot_mask_32 u_mask (
        .y    (in_y),
        .left (in_left),
        .mask (keep_mask)
    );

    assign rot_value = in_left ? rotl_value : rotr_value;

`ifdef ARITH_SHIFT_EN
    // Vacated bits are exactly the cleared mask bits, so sign-fill is ~mask.
    assign fill_bits = (in_arith && !in_left && !in_rot)
        ? (~keep_mask & {32{in_x[31]}})
        : 32'h0;
`else
    assign fill_bits = 32'h0;
`endif

    always_comb begin
        out_next = rot_value;
        if (!in_rot) begin
            out_next = (rot_value & keep_mask) | fill_bits;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_reg <= 32'h0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign out = out_reg;
endmodule

// File: tb/tb_shift_rot_unit_32.sv
// Directed-vector bench for shift_rot_unit_32; arithmetic vectors run only
// when ARITH_SHIFT_EN is defined.
module tb_shift_rot_unit_32;
    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic        left;
    logic        rot;
    logic        arith;
    logic [31:0] dout;

    int err_count;
    int chk_count;

    shift_rot_unit_32 dut (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_x     (x),
        .in_y     (y),
        .in_left  (left),
        .in_rot   (rot),
`ifdef ARITH_SHIFT_EN
        .in_arith (arith),
`endif
        .out      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%08h", tag, got);
        end
    endtask

    // Drive at the falling edge, sample 1 ns after the following rising edge.
    task automatic run(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                       input logic lv, input logic rv, input logic av,
                       input logic [31:0] exp);
        @(negedge clk);
        x = xv; y = yv; left = lv; rot = rv; arith = av;
        @(posedge clk);
        #1;
        check(tag, dout, exp);
    endtask

    localparam logic [31:0] XA = 32'hF000000F;
    localparam logic [31:0] XB = 32'h12345678;

    initial begin
        err_count = 0;
        chk_count = 0;
        rst = 1'b1;
        x = XA; y = 32'd3; left = 1'b0; rot = 1'b1; arith = 1'b0;
        #12;
        check("reset_state", dout, 32'h0);
        @(posedge clk);
        #1;
        check("reset_held", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //   tag            x    y              l     r     a
        run("shr_0",       XA, 32'd0,         1'b0, 1'b0, 1'b0, 32'hF000000F);
        run("ror_3",       XA, 32'd3,         1'b0, 1'b1, 1'b0, 32'hFE000001);
        run("shr_3",       XA, 32'd3,         1'b0, 1'b0, 1'b0, 32'h1E000001);
        run("rol_3",       XA, 32'd3,         1'b1, 1'b1, 1'b0, 32'h8000007F);
        run("shl_3",       XA, 32'd3,         1'b1, 1'b0, 1'b0, 32'h80000078);
        run("rol_35",      XA, 32'h23,        1'b1, 1'b1, 1'b0, 32'h8000007F);
        run("ror_35",      XA, 32'h23,        1'b0, 1'b1, 1'b0, 32'hFE000001);
        run("shl_255",     XA, 32'hFF,        1'b1, 1'b0, 1'b0, 32'h00000000);
        run("shr_32",      XA, 32'h20,        1'b0, 1'b0, 1'b0, 32'h00000000);
        run("shl_hibit",   XA, 32'h80000003,  1'b1, 1'b0, 1'b0, 32'h00000000);
        run("shl_31",      XA, 32'd31,        1'b1, 1'b0, 1'b0, 32'h80000000);
        run("shr_31",      XA, 32'd31,        1'b0, 1'b0, 1'b0, 32'h00000001);
        run("shr_4_b",     XB, 32'd4,         1'b0, 1'b0, 1'b0, 32'h01234567);
        run("rol_4_b",     XB, 32'd4,         1'b1, 1'b1, 1'b0, 32'h23456781);
        run("ror_8_b",     XB, 32'd8,         1'b0, 1'b1, 1'b0, 32'h78123456);
        run("shl_16_b",    XB, 32'd16,        1'b1, 1'b0, 1'b0, 32'h56780000);
        // back-to-back on consecutive cycles
        run("b2b_ror3",    XA, 32'd3,         1'b0, 1'b1, 1'b0, 32'hFE000001);
        run("b2b_shl3",    XA, 32'd3,         1'b1, 1'b0, 1'b0, 32'h80000078);
        run("b2b_rol0",    XA, 32'd0,         1'b1, 1'b1, 1'b0, 32'hF000000F);

`ifdef ARITH_SHIFT_EN
        run("asr_3",       XA, 32'd3,         1'b0, 1'b0, 1'b1, 32'hFE000001);
        run("asr_40",      XA, 32'd40,        1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        run("asr_3_pos",   32'h7000000F, 32'd3, 1'b0, 1'b0, 1'b1, 32'h0E000001);
        run("asr_40_pos",  32'h7000000F, 32'd40, 1'b0, 1'b0, 1'b1, 32'h00000000);
        run("asl_ignored", XA, 32'd3,         1'b1, 1'b0, 1'b1, 32'h80000078);
        run("aror_ignored",XA, 32'd3,         1'b0, 1'b1, 1'b1, 32'hFE000001);
`endif

        // Asynchronous reset mid-cycle: output clears without a clock edge.
        run("pre_rst",     XA, 32'd3,         1'b1, 1'b1, 1'b0, 32'h8000007F);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dout, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold", dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        x = XA; y = 32'd3; left = 1'b0; rot = 1'b0; arith = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_load", dout, 32'h1E000001);

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
